// File: rtl/iq_dsp_pkg.sv
// iq_dsp_pkg: widths and sideband select shared by the TX
// up-mixer and the RX down-mixer.
package iq_dsp_pkg;

    localparam int IQ_W  = 16;
    localparam int LO_W  = 12;
    localparam int OUT_W = 12;
    localparam int SUM_W = IQ_W + LO_W + 1;

    typedef enum logic {
        SB_USB = 1'b0,
        SB_LSB = 1'b1
    } sb_e;

endpackage

// File: rtl/iq_upmix_round_sat.sv
// round_sat: drops SHIFT LSBs with round-half-away-from-zero,
// then clips to a signed OUT_W result. Purely combinational.
module round_sat #(
    parameter int IN_W  = 29,
    parameter int SHIFT = 15,
    parameter int OUT_W = 12
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] val,
    output logic             sat
);

    localparam int RW = IN_W - SHIFT + 1;

    localparam logic signed [RW-1:0] MAX_R =
        RW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [RW-1:0] MIN_R = ~MAX_R;

    localparam logic [OUT_W-1:0] MAX_O =
        {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_O =
        {1'b1, {(OUT_W-1){1'b0}}};

    logic                 neg;
    logic                 half;
    logic                 rest;
    logic                 c;
    logic signed [RW-1:0] r;

    assign neg  = din[IN_W-1];
    assign half = din[SHIFT-1];
    assign rest = |din[SHIFT-2:0];

    // Negative exact ties must round down (away from zero).
    assign c = neg ? (half & rest) : half;

    assign r = {neg, din[IN_W-1:SHIFT]} + RW'(c);

    // Clip to the output range, flagging any clip.
    always_comb begin
        val = r[OUT_W-1:0];
        sat = 1'b0;
        unique case (1'b1)
            (r > MAX_R): begin
                val = MAX_O;
                sat = 1'b1;
            end
            (r < MIN_R): begin
                val = MIN_O;
                sat = 1'b1;
            end
            default: begin
                val = r[OUT_W-1:0];
                sat = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/iq_upmix.sv
// iq_upmix: TX quadrature up-mixer, dout = I*cos -/+ Q*sin.
// Optional sat event counter: IQ_UPMIX_SAT_CNT_EN.
module iq_upmix #(
    parameter int IQ_W  = iq_dsp_pkg::IQ_W,
    parameter int LO_W  = iq_dsp_pkg::LO_W,
    parameter int OUT_W = iq_dsp_pkg::OUT_W,
    parameter int SHIFT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IQ_W-1:0]  i_in,
    input  logic [IQ_W-1:0]  q_in,
    input  logic [LO_W-1:0]  cos_in,
    input  logic [LO_W-1:0]  sin_in,
    input  logic             sb_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] dout,
    output logic             sat,
    output logic [15:0]      sat_cnt,
    input  logic             sat_clr
);

    import iq_dsp_pkg::*;

    localparam int PW = IQ_W + LO_W;
    localparam int SW = PW + 1;

    logic                 stall;
    logic                 v1;
    logic                 v2;
    sb_e                  sb1;
    logic signed [PW-1:0] pi;
    logic signed [PW-1:0] pq;
    logic signed [SW-1:0] s;
    logic [OUT_W-1:0]     rs_val;
    logic                 rs_sat;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // Stage 1: full-precision products and sideband select.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1  <= 1'b0;
            sb1 <= SB_USB;
            pi  <= '0;
            pq  <= '0;
        end else if (!stall) begin
            v1 <= in_valid;
            if (in_valid) begin
                sb1 <= sb_e'(sb_sel);
                pi  <= PW'($signed(i_in))
                     * PW'($signed(cos_in));
                pq  <= PW'($signed(q_in))
                     * PW'($signed(sin_in));
            end
        end
    end

    // Stage 2: sideband sum, one guard bit so it never overflows.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2 <= 1'b0;
            s  <= '0;
        end else if (!stall) begin
            v2 <= v1;
            if (v1) begin
                if (sb1 == SB_LSB)
                    s <= SW'(pi) + SW'(pq);
                else
                    s <= SW'(pi) - SW'(pq);
            end
        end
    end

    round_sat #(
        .IN_W  (SW),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_round_sat (
        .din (s),
        .val (rs_val),
        .sat (rs_sat)
    );

    // Stage 3: output register; dout/sat hold across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            dout      <= '0;
            sat       <= 1'b0;
        end else if (!stall) begin
            out_valid <= v2;
            if (v2) begin
                dout <= rs_val;
                sat  <= rs_sat;
            end
        end
    end

`ifdef IQ_UPMIX_SAT_CNT_EN
    // Count clipped output transfers; clear wins, no wrap.
    always_ff @(posedge clk) begin
        if (rst)
            sat_cnt <= '0;
        else if (sat_clr)
            sat_cnt <= '0;
        else if (out_valid && out_ready && sat
                 && sat_cnt != 16'hFFFF)
            sat_cnt <= sat_cnt + 16'd1;
    end
`else
    logic unused_sat_clr;

    assign unused_sat_clr = sat_clr;
    assign sat_cnt        = '0;
`endif

endmodule

// File: tb/tb_iq_upmix.sv
// tb_iq_upmix: scoreboard bench for iq_upmix; the sat counter
// checks follow IQ_UPMIX_SAT_CNT_EN.
module tb_iq_upmix;

    typedef struct packed {
        logic        s;
        logic [11:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] i_in = '0;
    logic [15:0] q_in = '0;
    logic [11:0] cos_in = '0;
    logic [11:0] sin_in = '0;
    logic        sb_sel = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] dout;
    logic        sat;
    logic [15:0] sat_cnt;
    logic        sat_clr = 1'b0;

    exp_t sb_q[$];
    int   compared = 0;
    int   mismatched = 0;
    bit   saw_stall = 1'b0;

    always #5 clk = ~clk;

    iq_upmix dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .i_in      (i_in),
        .q_in      (q_in),
        .cos_in    (cos_in),
        .sin_in    (sin_in),
        .sb_sel    (sb_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .sat       (sat),
        .sat_cnt   (sat_cnt),
        .sat_clr   (sat_clr)
    );

    task automatic chk(input string nm, input int act,
                       input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d want %0d",
                     nm, act, exp);
        end
    endtask

    // Monitor: an output transfers at the next posedge.
    always @(negedge clk) begin
        exp_t e;
        if (!in_ready) saw_stall = 1'b1;
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_out: got %0d want none",
                         $signed(dout));
            end else begin
                e = sb_q.pop_front();
                chk("dout", $signed(dout), $signed(e.d));
                chk("sat", int'(sat), int'(e.s));
            end
        end
    end

    task automatic send(input int i, input int q,
                        input int c, input int s,
                        input bit sb, input int ed,
                        input bit es);
        int n;
        exp_t e;
        i_in     = 16'(i);
        q_in     = 16'(q);
        cos_in   = 12'(c);
        sin_in   = 12'(s);
        sb_sel   = sb;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 0, 1);
        end else begin
            e.s = es;
            e.d = 12'(ed);
            sb_q.push_back(e);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0)
            chk("drain_timeout", sb_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic set_ready(input bit v);
        @(posedge clk);
        #2 out_ready = v;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_dout", int'(dout), 0);
        chk("rst_sat", int'(sat), 0);
        chk("rst_sat_cnt", int'(sat_cnt), 0);

        // Exact ties round away from zero.
        send(16384, 0, 2047, 0, 1'b0, 1024, 1'b0);
        send(-16384, 0, 2047, 0, 1'b0, -1024, 1'b0);
        drain();

        // Clipping both ways.
        send(32767, -32768, 2047, 2047, 1'b0, 2047, 1'b1);
        send(32767, -32768, -2047, -2047, 1'b0, -2048, 1'b1);
        drain();

        // Sideband select.
        send(0, 16384, 0, 2047, 1'b0, -1024, 1'b0);
        send(0, 16384, 0, 2047, 1'b1, 1024, 1'b0);
        drain();

        // Ramp with a 5-cycle downstream stall mid-stream.
        saw_stall = 1'b0;
        fork
            begin
                for (int k = 0; k < 10; k++)
                    send(k * 1024, 0, 1024, 0, 1'b0,
                         k * 32, 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                #2 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        drain();
        chk("in_ready_drop", int'(saw_stall), 1);

        // Reset with three samples in flight.
        set_ready(1'b0);
        send(1024, 0, 1024, 0, 1'b0, 32, 1'b0);
        send(2048, 0, 1024, 0, 1'b0, 64, 1'b0);
        send(3072, 0, 1024, 0, 1'b0, 96, 1'b0);
        chk("pipe_full", int'(out_valid), 1);
        chk("pipe_stall", int'(in_ready), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_dout", int'(dout), 0);
        rst = 1'b0;
        sb_q.delete();
        set_ready(1'b1);
        send(5120, 0, 1024, 0, 1'b0, 160, 1'b0);
        chk("lat_c1", int'(out_valid), 0);
        @(negedge clk);
        chk("lat_c2", int'(out_valid), 0);
        @(negedge clk);
        chk("lat_c3", int'(out_valid), 1);
        drain();

`ifdef IQ_UPMIX_SAT_CNT_EN
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        chk("cnt_clr", int'(sat_cnt), 0);
        for (int k = 0; k < 4; k++)
            send(32767, -32768, 2047, 2047, 1'b0,
                 2047, 1'b1);
        drain();
        chk("cnt_4", int'(sat_cnt), 4);

        send(32767, -32768, 2047, 2047, 1'b0, 2047, 1'b1);
        for (int n = 0; n < 20 && !out_valid; n++)
            @(negedge clk);
        chk("cnt_pre_clr_valid", int'(out_valid), 1);
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        chk("cnt_clr_beats_inc", int'(sat_cnt), 0);
        drain();

        for (int k = 0; k < 65535; k++)
            send(32767, -32768, 2047, 2047, 1'b0,
                 2047, 1'b1);
        drain();
        chk("cnt_full", int'(sat_cnt), 65535);
        send(32767, -32768, 2047, 2047, 1'b0, 2047, 1'b1);
        drain();
        chk("cnt_no_wrap", int'(sat_cnt), 65535);
`else
        chk("cnt_tied", int'(sat_cnt), 0);
        sat_clr = 1'b1;
        send(32767, -32768, 2047, 2047, 1'b0, 2047, 1'b1);
        sat_clr = 1'b0;
        drain();
        chk("cnt_tied_after", int'(sat_cnt), 0);
`endif

        chk("queue_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
